fp16_int_decoder: RTL and testbench

Sequential converter from IEEE-754 half-precision (FP16) to a saturated signed integer. It is the decode-side counterpart of the FP16 adder datapath: adder results (e.g. 0x5C2C) come back as integers (267) for checking and downstream integer logic. It uses an iterative one-bit-per-cycle shifter with a valid/ready handshake on both sides and truncates toward zero.

---
 rtl/fp16_int_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_fp16_int_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_int_decoder.sv
// fp16_int_decoder
// Converts an IEEE-754 half-precision operand into a saturated signed
// OUT_W-bit integer, truncating toward zero. The mantissa is aligned by
// an iterative shifter that moves one bit per cycle.
//
// Ports
//   clk_34        clock, rising edge
//   rst_34        synchronous active-low reset
//   fp_in_34      FP16 operand {sign, exp[4:0], frac[9:0]}
//   in_valid_34   operand valid        in_ready_34   block idle, accepts operand
//   int_out_34    two's-complement result
//   out_valid_34  result valid         out_ready_34  consumer accepts result
//   Ovf_Flag_34   result saturated (out of range or infinity)
//   Inx_Flag_34   nonzero fraction bits were discarded
//   Nan_Flag_34   operand was NaN
//   state_dbg_34  current FSM state (IDLE=0, DECODE=1, SHIFT=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready_34 is high only in IDLE; out_valid_34 is high only in
// DONE and the result and flags are held stable until out_ready_34 is seen.
module fp16_int_decoder #(
  parameter int OUT_W = 16
) (
  input  logic             clk_34,
  input  logic             rst_34,
  input  logic [15:0]      fp_in_34,
  input  logic             in_valid_34,
  output logic             in_ready_34,
  output logic [OUT_W-1:0] int_out_34,
  output logic             out_valid_34,
  input  logic             out_ready_34,
  output logic             Ovf_Flag_34,
  output logic             Inx_Flag_34,
  output logic             Nan_Flag_34,
  output logic [1:0]       state_dbg_34
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SHIFT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      fp_q, fp_d;
  logic [15:0]      mag_q, mag_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sticky_q, sticky_d;
  logic             is_nan_q, is_nan_d;
  logic             is_inf_q, is_inf_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             inx_q, inx_d;
  logic             nan_q, nan_d;

  logic [4:0]       exp_w;
  logic [9:0]       frac_w;
  logic             sign_w;
  logic [32:0]      lim_pos;
  logic [32:0]      lim_neg_mag;
  logic [32:0]      mag_ext;
  logic             too_big;
  logic [OUT_W-1:0] sat_val;
  logic [OUT_W-1:0] mag_w;
  logic [OUT_W-1:0] signed_val;

  assign exp_w  = fp_q[14:10];
  assign frac_w = fp_q[9:0];
  assign sign_w = fp_q[15];

  // Largest positive magnitude, and the one extra value only negatives reach.
  assign lim_pos     = {{(34-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  assign lim_neg_mag = lim_pos + 33'd1;
  assign mag_ext     = {17'd0, mag_q};
  assign too_big     = sign_w ? (mag_ext > lim_neg_mag) : (mag_ext > lim_pos);
  assign sat_val     = sign_w ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  assign mag_w       = OUT_W'(mag_q);
  // Negating zero yields zero, so -0 needs no special case.
  assign signed_val  = sign_w ? (~mag_w + 1'b1) : mag_w;

  // State register
  always_ff @(posedge clk_34) begin
    if (!rst_34) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid_34) state_d = S_DECODE;
      S_DECODE: state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:   if (out_ready_34) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_34  = 1'b0;
    out_valid_34 = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_34  = 1'b1;
      S_DONE:  out_valid_34 = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg_34 = state_q;
  assign int_out_34   = res_q;
  assign Ovf_Flag_34  = ovf_q;
  assign Inx_Flag_34  = inx_q;
  assign Nan_Flag_34  = nan_q;

  // Datapath
  always_comb begin
    fp_d     = fp_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    is_nan_d = is_nan_q;
    is_inf_d = is_inf_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    inx_d    = inx_q;
    nan_d    = nan_q;
    case (state_q)
      S_IDLE: if (in_valid_34) fp_d = fp_in_34;
      S_DECODE: begin
        // Specials and |x|<1 fall through SHIFT with a zero count so every
        // path finalizes in the same place.
        mag_d    = 16'd0;
        cnt_d    = 4'd0;
        left_d   = 1'b0;
        sticky_d = 1'b0;
        is_nan_d = 1'b0;
        is_inf_d = 1'b0;
        if (exp_w == 5'd31) begin
          if (frac_w != 10'd0) is_nan_d = 1'b1;
          else                 is_inf_d = 1'b1;
        end else if (exp_w == 5'd0) begin
          sticky_d = (frac_w != 10'd0);
        end else if (exp_w < 5'd15) begin
          sticky_d = 1'b1;
        end else if (exp_w <= 5'd25) begin
          mag_d = {5'd0, 1'b1, frac_w};
          cnt_d = 4'(5'd25 - exp_w);
        end else begin
          mag_d  = {5'd0, 1'b1, frac_w};
          cnt_d  = 4'(exp_w - 5'd25);
          left_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != 4'd0) begin
          if (left_q) begin
            mag_d = {mag_q[14:0], 1'b0};
          end else begin
            mag_d    = {1'b0, mag_q[15:1]};
            sticky_d = sticky_q | mag_q[0];
          end
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Result and flags are replaced only here, on entry to DONE.
          nan_d = is_nan_q;
          inx_d = 1'b0;
          ovf_d = 1'b0;
          if (is_nan_q) begin
            res_d = '0;
          end else if (is_inf_q) begin
            res_d = sat_val;
            ovf_d = 1'b1;
          end else begin
            inx_d = sticky_q;
            if (too_big) begin
              res_d = sat_val;
              ovf_d = 1'b1;
            end else begin
              res_d = signed_val;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_34) begin
    if (!rst_34) begin
      fp_q     <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sticky_q <= 1'b0;
      is_nan_q <= 1'b0;
      is_inf_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      inx_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      fp_q     <= fp_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sticky_q <= sticky_d;
      is_nan_q <= is_nan_d;
      is_inf_q <= is_inf_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      inx_q    <= inx_d;
      nan_q    <= nan_d;
    end
  end

endmodule

// File: tb/tb_fp16_int_decoder.sv
// Testbench for fp16_int_decoder (OUT_W=16): directed cases with literal
// expectations, back-pressure, reset mid-conversion and randomized operands
// checked against a numeric model of FP16-to-integer truncation.
module tb_fp16_int_decoder;
  localparam int OUT_W = 16;
  localparam int W     = OUT_W + 3;

  logic             clk;
  logic             rst_n;
  logic [15:0]      fp_in;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] int_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf, inx, nan;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  fp16_int_decoder #(.OUT_W(OUT_W)) dut (
    .clk_34      (clk),
    .rst_34      (rst_n),
    .fp_in_34    (fp_in),
    .in_valid_34 (in_valid),
    .in_ready_34 (in_ready),
    .int_out_34  (int_out),
    .out_valid_34(out_valid),
    .out_ready_34(out_ready),
    .Ovf_Flag_34 (ovf),
    .Inx_Flag_34 (inx),
    .Nan_Flag_34 (nan),
    .state_dbg_34(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Numeric model: value = (1024+frac) * 2^(exp-25), truncated, then clamped.
  function automatic logic [W-1:0] model(input logic [15:0] fp);
    int     e, f, sh;
    longint m, mag, v, lim;
    logic   s, o, x, n;
    logic [W-1:0] r;
    s = fp[15]; e = int'(fp[14:10]); f = int'(fp[9:0]);
    lim = longint'(1) <<< (OUT_W - 1);
    o = 1'b0; x = 1'b0; n = 1'b0; v = 0;
    if (e == 31) begin
      if (f != 0) n = 1'b1;
      else begin o = 1'b1; v = s ? -lim : lim - 1; end
    end else begin
      if (e == 0) begin
        mag = 0; x = (f != 0);
      end else begin
        m = 1024 + f;
        if (e >= 25) mag = m <<< (e - 25);
        else begin
          sh  = 25 - e;
          mag = m >>> sh;
          x   = ((m % (longint'(1) <<< sh)) != 0);
        end
      end
      v = s ? -mag : mag;
      if (v > lim - 1) begin v = lim - 1; o = 1'b1; end
      if (v < -lim)    begin v = -lim;    o = 1'b1; end
    end
    r = {v[OUT_W-1:0], o, x, n};
    return r;
  endfunction

  function automatic int model_lat(input logic [15:0] fp);
    int e;
    e = int'(fp[14:10]);
    if (e >= 15 && e <= 24) return 2 + (25 - e);
    if (e >= 26 && e <= 30) return 2 + (e - 25);
    return 2;
  endfunction

  // Scoreboard compare: every cycle the result is valid it must match the
  // head of the expected queue; it is retired when the consumer accepts.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        chk("result", {int_out, ovf, inx, nan}, exp_q[0]);
        chk("in_ready_in_done", in_ready, 1'b0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Driver: one conversion, out_ready held low for 'hold' cycles of DONE.
  task automatic send(input logic [15:0] fp, input int hold,
                      output logic [W-1:0] got, output int lat);
    int n;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    fp_in = fp; in_valid = 1'b1;
    exp_q.push_back(model(fp));
    @(negedge clk);
    in_valid = 1'b0;
    fp_in = 16'($urandom);
    wait_valid(lat);
    chk("latency", lat, model_lat(fp));
    got = {int_out, ovf, inx, nan};
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin @(negedge clk); n++; end
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
  endtask

  logic [15:0] fp_tab[11] = '{16'h5C2C, 16'hDD74, 16'h5A90, 16'hC920, 16'h3C00, 16'h0001,
                              16'h8000, 16'h78E2, 16'hF800, 16'hFC00, 16'h7E00};
  logic [W-1:0] exp_tab[11] = '{{16'h010B, 3'b000}, {16'hFEA3, 3'b000}, {16'h00D2, 3'b000},
                                {16'hFFF6, 3'b010}, {16'h0001, 3'b000}, {16'h0000, 3'b010},
                                {16'h0000, 3'b000}, {16'h7FFF, 3'b100}, {16'h8000, 3'b000},
                                {16'h8000, 3'b100}, {16'h0000, 3'b001}};
  int lat_tab[11] = '{4, 4, 5, 9, 12, 2, 2, 7, 7, 2, 2};

  initial begin
    logic [W-1:0] got;
    logic [15:0]  r;
    int           lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fp_in = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {int_out, ovf, inx, nan}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // Model pins and directed cases
    for (int i = 0; i < 11; i++) begin
      chk("model_pin", model(fp_tab[i]), exp_tab[i]);
      chk("model_lat_pin", model_lat(fp_tab[i]), lat_tab[i]);
      send(fp_tab[i], 0, got, lat);
      chk("dir_result", got, exp_tab[i]);
      chk("dir_latency", lat, lat_tab[i]);
    end

    // Back-pressure: result held 5 cycles, second operand ignored until IDLE
    out_ready = 1'b0;
    fp_in = 16'h5C2C; in_valid = 1'b1;
    exp_q.push_back(model(16'h5C2C));
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", lat, 4);
    fp_in = 16'h5A90; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    exp_q.push_back(model(16'h5A90));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("bp_second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_second_latency", lat, 5);
    chk("bp_second_result", {int_out, ovf, inx, nan}, {16'h00D2, 3'b000});
    @(negedge clk);

    // Reset in the middle of the shifter
    out_ready = 1'b1;
    fp_in = 16'h3C00; in_valid = 1'b1;
    exp_q.push_back(model(16'h3C00));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_outputs", {int_out, ovf, inx, nan}, '0);
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("midrst_no_pulse", out_valid, 1'b0);
    end
    send(16'h5C2C, 0, got, lat);
    chk("after_rst_result", got, {16'h010B, 3'b000});

    // Randomized operands with random consumer stalls
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) r[14:10] = 5'($urandom_range(12, 31));
      send(r, $urandom_range(0, 3), got, lat);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
